// File: rtl/coeff_bank_pkg.sv
// rtl/coeff_bank_pkg.sv - shared types and helpers for the coefficient bank
//
// Contents:
//   commit_state_t : commit FSM states (IDLE, PENDING)
//   even_parity()  : even-parity bit over the low 'width' bits of a word
package coeff_bank_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_t;

  // Widest coefficient word the parity helper accepts; callers zero-extend.
  localparam int PAR_MAX_W = 64;

  // Returns the bit that makes the total count of ones (word + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word,
                                       input int width);
    logic p;
    p = 1'b0;
    for (int i = 0; i < PAR_MAX_W; i++) begin
      if (i < width) p = p ^ word[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/coeff_cfg_port.sv
// rtl/coeff_cfg_port.sv - host config port: addressing, pointer, range check, read regs
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   cfg_addr, cfg_autoinc  : direct address / select internal pointer
//   cfg_wr, cfg_rd         : write / read strobes (write wins on collision)
//   shadow_q               : shadow word at shadow_idx (combinational from top)
//   shadow_idx, shadow_we  : shadow bank index and qualified write enable
//   cfg_rdata, cfg_rvalid  : registered read data and valid pulse
//   cfg_err                : registered pulse on an out-of-range access
module coeff_cfg_port
  import coeff_bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 8,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              cfg_wr,
  input  logic              cfg_rd,
  input  logic              cfg_autoinc,
  input  logic [DATA_W-1:0] shadow_q,
  output logic [IDX_W-1:0]  shadow_idx,
  output logic              shadow_we,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              cfg_rvalid,
  output logic              cfg_err
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ea;
  logic [ADDR_W-1:0] ea_next;
  logic              in_range;
  logic              access;
  logic              rd_only;

  assign ea       = cfg_autoinc ? ptr : cfg_addr;
  assign in_range = ({1'b0, ea} < DEPTH_EXT);
  assign ea_next  = ({1'b0, ea} == (DEPTH_EXT - 1'b1)) ? '0 : ea + 1'b1;
  assign access   = cfg_wr | cfg_rd;
  // A read colliding with a write is dropped entirely.
  assign rd_only  = cfg_rd & ~cfg_wr;

  assign shadow_idx = ea[IDX_W-1:0];
  assign shadow_we  = cfg_wr & in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      cfg_rdata  <= '0;
      cfg_rvalid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_rvalid <= rd_only;
      cfg_err    <= access & ~in_range;
      if (rd_only) cfg_rdata <= in_range ? shadow_q : '0;
      // Out-of-range accesses leave the pointer where it was.
      if (access && in_range) ptr <= ea_next;
    end
  end

endmodule

// File: rtl/coeff_bank.sv
// rtl/coeff_bank.sv - double-buffered coefficient store with frame-aligned commit
//
// Optional feature macro: CFG_PARITY_EN (per-word even parity, checked on tap read)
//
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   cfg_addr/wdata/wr/rd/autoinc       : host access to the shadow bank
//   cfg_rdata, cfg_rvalid, cfg_err     : host read response / error pulse
//   commit_req, frame_sync             : copy request, frame boundary strobe
//   commit_pending, commit_done        : request outstanding / copy-done pulse
//   tap_addr, tap_data, tap_perr       : registered datapath read of the active bank
module coeff_bank
  import coeff_bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              cfg_wr,
  input  logic              cfg_rd,
  input  logic              cfg_autoinc,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              cfg_rvalid,
  output logic              cfg_err,
  input  logic              commit_req,
  input  logic              frame_sync,
  output logic              commit_pending,
  output logic              commit_done,
  input  logic [ADDR_W-1:0] tap_addr,
  output logic [DATA_W-1:0] tap_data,
  output logic              tap_perr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] shadow_mem [DEPTH];
  logic [DATA_W-1:0] active_mem [DEPTH];

  logic [IDX_W-1:0]  shadow_idx;
  logic              shadow_we;
  logic [DATA_W-1:0] shadow_q;

  assign shadow_q = shadow_mem[shadow_idx];

  coeff_cfg_port #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_cfg_port (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_addr    (cfg_addr),
    .cfg_wr      (cfg_wr),
    .cfg_rd      (cfg_rd),
    .cfg_autoinc (cfg_autoinc),
    .shadow_q    (shadow_q),
    .shadow_idx  (shadow_idx),
    .shadow_we   (shadow_we),
    .cfg_rdata   (cfg_rdata),
    .cfg_rvalid  (cfg_rvalid),
    .cfg_err     (cfg_err)
  );

  // ---------------- commit FSM ----------------
  commit_state_t state;
  logic          copy_now;

  assign copy_now = frame_sync & (commit_req | (state == PENDING));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
    end else begin
      commit_done <= copy_now;
      case (state)
        IDLE: begin
          if (commit_req && !frame_sync) begin
            state          <= PENDING;
            commit_pending <= 1'b1;
          end
        end
        PENDING: begin
          // Extra commit_req here is absorbed into the outstanding one.
          if (frame_sync) begin
            state          <= IDLE;
            commit_pending <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          commit_pending <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- banks ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) shadow_mem[i] <= '0;
    end else if (shadow_we) begin
      shadow_mem[shadow_idx] <= cfg_wdata;
    end
  end

  // Non-blocking copy samples shadow before this cycle's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) active_mem[i] <= '0;
    end else if (copy_now) begin
      for (int i = 0; i < DEPTH; i++) active_mem[i] <= shadow_mem[i];
    end
  end

  // ---------------- tap port ----------------
  logic             tap_in_range;
  logic [IDX_W-1:0] tap_idx;

  assign tap_in_range = ({1'b0, tap_addr} < DEPTH_EXT);
  assign tap_idx      = tap_addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_data <= '0;
    end else begin
      tap_data <= tap_in_range ? active_mem[tap_idx] : '0;
    end
  end

`ifdef CFG_PARITY_EN
  logic shadow_par [DEPTH];
  logic active_par [DEPTH];
  logic wdata_par;
  logic tap_calc_par;
  logic [PAR_MAX_W-1:0] wdata_ext;
  logic [PAR_MAX_W-1:0] tap_ext;

  always_comb begin
    wdata_ext = '0;
    wdata_ext[DATA_W-1:0] = cfg_wdata;
    tap_ext = '0;
    tap_ext[DATA_W-1:0] = active_mem[tap_idx];
    wdata_par    = even_parity(wdata_ext, DATA_W);
    tap_calc_par = even_parity(tap_ext, DATA_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) shadow_par[i] <= 1'b0;
    end else if (shadow_we) begin
      shadow_par[shadow_idx] <= wdata_par;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) active_par[i] <= 1'b0;
    end else if (copy_now) begin
      for (int i = 0; i < DEPTH; i++) active_par[i] <= shadow_par[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_perr <= 1'b0;
    end else begin
      tap_perr <= tap_in_range & (tap_calc_par != active_par[tap_idx]);
    end
  end
`else
  assign tap_perr = 1'b0;
`endif

endmodule

// File: tb/tb_coeff_bank.sv
// tb/tb_coeff_bank.sv - self-checking bench for coeff_bank with a behavioural model
module tb_coeff_bank;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          cfg_wr;
  logic          cfg_rd;
  logic          cfg_autoinc;
  logic [DW-1:0] cfg_rdata;
  logic          cfg_rvalid;
  logic          cfg_err;
  logic          commit_req;
  logic          frame_sync;
  logic          commit_pending;
  logic          commit_done;
  logic [AW-1:0] tap_addr;
  logic [DW-1:0] tap_data;
  logic          tap_perr;

  always #5 clk = ~clk;

  coeff_bank #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_wr         (cfg_wr),
    .cfg_rd         (cfg_rd),
    .cfg_autoinc    (cfg_autoinc),
    .cfg_rdata      (cfg_rdata),
    .cfg_rvalid     (cfg_rvalid),
    .cfg_err        (cfg_err),
    .commit_req     (commit_req),
    .frame_sync     (frame_sync),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .tap_addr       (tap_addr),
    .tap_data       (tap_data),
    .tap_perr       (tap_perr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_shadow [DEPTH];
  int m_active [DEPTH];
  int m_ptr;
  bit m_pending;
  int e_rdata, e_tap;
  bit e_rvalid, e_err, e_done, e_pending, e_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_ptr = 0; m_pending = 0;
    e_rdata = 0; e_tap = 0;
    e_rvalid = 0; e_err = 0; e_done = 0; e_pending = 0; e_perr = 0;
  endtask

  // Predict registered outputs after the coming edge from the current inputs.
  task automatic model_step();
    int ea;
    bit inr, copy;
    ea  = cfg_autoinc ? m_ptr : int'(cfg_addr);
    inr = (ea < DEPTH);
    e_err    = (cfg_wr || cfg_rd) && !inr;
    e_rvalid = cfg_rd && !cfg_wr;
    if (e_rvalid) e_rdata = inr ? m_shadow[ea] : 0;
    e_tap  = (int'(tap_addr) < DEPTH) ? m_active[tap_addr] : 0;
    e_perr = 0;
    copy   = frame_sync && (commit_req || m_pending);
    e_done = copy;
    if (m_pending) m_pending = !frame_sync;
    else           m_pending = commit_req && !frame_sync;
    e_pending = m_pending;
    if (copy) for (int i = 0; i < DEPTH; i++) m_active[i] = m_shadow[i];
    if (cfg_wr && inr) m_shadow[ea] = int'(cfg_wdata);
    if ((cfg_wr || cfg_rd) && inr) m_ptr = (ea + 1) % DEPTH;
  endtask

  task automatic check_outputs();
    chk("cfg_rvalid", cfg_rvalid, e_rvalid);
    if (e_rvalid) chk("cfg_rdata", cfg_rdata, e_rdata);
    chk("cfg_err", cfg_err, e_err);
    chk("commit_pending", commit_pending, e_pending);
    chk("commit_done", commit_done, e_done);
    chk("tap_data", tap_data, e_tap);
    chk("tap_perr", tap_perr, e_perr);
  endtask

  task automatic idle();
    cfg_addr = '0; cfg_wdata = '0; cfg_wr = 0; cfg_rd = 0; cfg_autoinc = 0;
    commit_req = 0; frame_sync = 0; tap_addr = '0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    idle();
  endtask

  task automatic cfg_write(input bit ai, input int addr, input int data);
    cfg_wr = 1; cfg_autoinc = ai; cfg_addr = AW'(addr); cfg_wdata = DW'(data);
    step();
  endtask

  task automatic cfg_read(input bit ai, input int addr);
    cfg_rd = 1; cfg_autoinc = ai; cfg_addr = AW'(addr);
    step();
  endtask

  task automatic tap_read(input int addr);
    tap_addr = AW'(addr);
    step();
  endtask

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;

    // Reset state
    chk("rst cfg_rdata", cfg_rdata, 0);
    chk("rst cfg_rvalid", cfg_rvalid, 0);
    chk("rst cfg_err", cfg_err, 0);
    chk("rst commit_pending", commit_pending, 0);
    chk("rst commit_done", commit_done, 0);
    chk("rst tap_data", tap_data, 0);
    chk("rst tap_perr", tap_perr, 0);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      tap_read(i);
      chk("rst tap sweep", tap_data, 0);
    end

    // Auto-increment wrap: 0x11..0x20 then 0xAA lands at word 0
    for (int i = 0; i < DEPTH; i++) begin
      tap_addr = AW'(i);
      cfg_write(1, 0, 'h11 + i);
      chk("autoinc tap still 0", tap_data, 0);
    end
    cfg_write(1, 0, 'hAA);
    cfg_read(1, 0);
    chk("autoinc ptr=1 readback", cfg_rdata, 'h12);
    cfg_read(0, 0);
    chk("autoinc shadow[0]", cfg_rdata, 'hAA);
    cfg_read(0, 15);
    chk("autoinc shadow[15]", cfg_rdata, 'h20);

    // Deferred commit: req, 9 idle cycles, then frame_sync
    commit_req = 1;
    step();
    chk("deferred pending rise", commit_pending, 1);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("deferred pending hold", commit_pending, 1);
    end
    frame_sync = 1;
    step();
    chk("deferred pending fall", commit_pending, 0);
    chk("deferred done", commit_done, 1);
    tap_read(3);
    chk("deferred tap[3]", tap_data, 'h14);
    chk("deferred done one-shot", commit_done, 0);

    // Same-cycle write and commit
    cfg_write(0, 2, 'h55);
    cfg_wr = 1; cfg_addr = AW'(2); cfg_wdata = 8'h66;
    commit_req = 1; frame_sync = 1;
    step();
    chk("samecycle done", commit_done, 1);
    chk("samecycle no pending", commit_pending, 0);
    tap_read(2);
    chk("samecycle active[2]", tap_data, 'h55);
    cfg_read(0, 2);
    chk("samecycle shadow[2]", cfg_rdata, 'h66);

    // Out-of-range and collision
    cfg_write(0, 16, 'h77);
    chk("oor write err", cfg_err, 1);
    cfg_read(0, 16);
    chk("oor read rvalid", cfg_rvalid, 1);
    chk("oor read rdata", cfg_rdata, 0);
    chk("oor read err", cfg_err, 1);
    cfg_read(0, 0);
    chk("oor no bank change", cfg_rdata, 'hAA);
    cfg_wr = 1; cfg_rd = 1; cfg_addr = AW'(4); cfg_wdata = 8'h3C;
    step();
    chk("collision no rvalid", cfg_rvalid, 0);
    cfg_read(0, 4);
    chk("collision write done", cfg_rdata, 'h3C);
    tap_read(20);
    chk("oor tap", tap_data, 0);

    // Reset mid-operation discards a pending commit and clears the banks
    commit_req = 1;
    step();
    chk("midrst pending before", commit_pending, 1);
    rst_n = 0;
    model_reset();
    #1;
    chk("midrst pending cleared", commit_pending, 0);
    @(negedge clk);
    rst_n = 1;
    frame_sync = 1;
    step();
    chk("midrst no done", commit_done, 0);
    for (int i = 0; i < DEPTH; i++) tap_read(i);
    cfg_read(0, 4);
    chk("midrst shadow cleared", cfg_rdata, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cfg_autoinc = ($urandom_range(0, 1) == 1);
      cfg_addr    = AW'($urandom_range(0, 19));
      cfg_wdata   = DW'($urandom);
      cfg_wr      = ($urandom_range(0, 9) < 4);
      cfg_rd      = ($urandom_range(0, 9) < 4);
      commit_req  = ($urandom_range(0, 9) == 0);
      frame_sync  = ($urandom_range(0, 9) == 0);
      tap_addr    = AW'($urandom_range(0, 19));
      step();
    end

`ifdef CFG_PARITY_EN
    // Corrupt one stored active bit; only address 5 may flag.
    dut.active_mem[5][0] = ~dut.active_mem[5][0];
    for (int i = 0; i < 20; i++) begin
      tap_addr = AW'(i);
      @(posedge clk);
      @(negedge clk);
      chk("parity flag", tap_perr, (i == 5) ? 1 : 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
